// File: rtl/m2_compute_t.sv
// m2_compute_t: first IDCT matrix stage, T = S' x C for one 8x8 block, written to the T RAM.
// Each row is loaded into a row buffer, then each column is reduced with a single multiplier.
module m2_compute_t #(
  parameter int ACC_W = 32,
  parameter int SHIFT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        done_o,
  output logic [4:0]  sp_address_o,
  input  logic [31:0] sp_read_data_i,
  output logic [5:0]  t_address_o,
  output logic [31:0] t_write_data_o,
  output logic        t_we_o,
  output logic        busy_o
);
  typedef enum logic [3:0] {IDLE, LOAD0, LOAD1, LOAD2, LOAD3, LOAD4, MAC, WRITE, DONE} state_t;
  state_t                   state_q, state_d;
  logic [2:0]               row_q, row_d, col_q, col_d, k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [15:0]       rowbuf_q [8];
  logic signed [15:0]       rowbuf_d [8];
  logic signed [15:0]       c_rom;
  logic signed [31:0]       prod;
  logic [1:0]               load_idx;
  always_comb begin
    c_rom = '0;
    case ({k_q, col_q})
      6'o00: c_rom = 16'sd1448;  6'o01: c_rom = 16'sd1448;  6'o02: c_rom = 16'sd1448;  6'o03: c_rom = 16'sd1448;
      6'o04: c_rom = 16'sd1448;  6'o05: c_rom = 16'sd1448;  6'o06: c_rom = 16'sd1448;  6'o07: c_rom = 16'sd1448;
      6'o10: c_rom = 16'sd2008;  6'o11: c_rom = 16'sd1702;  6'o12: c_rom = 16'sd1137;  6'o13: c_rom = 16'sd399;
      6'o14: c_rom = -16'sd399;  6'o15: c_rom = -16'sd1137; 6'o16: c_rom = -16'sd1702; 6'o17: c_rom = -16'sd2008;
      6'o20: c_rom = 16'sd1892;  6'o21: c_rom = 16'sd783;   6'o22: c_rom = -16'sd783;  6'o23: c_rom = -16'sd1892;
      6'o24: c_rom = -16'sd1892; 6'o25: c_rom = -16'sd783;  6'o26: c_rom = 16'sd783;   6'o27: c_rom = 16'sd1892;
      6'o30: c_rom = 16'sd1702;  6'o31: c_rom = -16'sd399;  6'o32: c_rom = -16'sd2008; 6'o33: c_rom = -16'sd1137;
      6'o34: c_rom = 16'sd1137;  6'o35: c_rom = 16'sd2008;  6'o36: c_rom = 16'sd399;   6'o37: c_rom = -16'sd1702;
      6'o40: c_rom = 16'sd1448;  6'o41: c_rom = -16'sd1448; 6'o42: c_rom = -16'sd1448; 6'o43: c_rom = 16'sd1448;
      6'o44: c_rom = 16'sd1448;  6'o45: c_rom = -16'sd1448; 6'o46: c_rom = -16'sd1448; 6'o47: c_rom = 16'sd1448;
      6'o50: c_rom = 16'sd1137;  6'o51: c_rom = -16'sd2008; 6'o52: c_rom = 16'sd399;   6'o53: c_rom = 16'sd1702;
      6'o54: c_rom = -16'sd1702; 6'o55: c_rom = -16'sd399;  6'o56: c_rom = 16'sd2008;  6'o57: c_rom = -16'sd1137;
      6'o60: c_rom = 16'sd783;   6'o61: c_rom = -16'sd1892; 6'o62: c_rom = 16'sd1892;  6'o63: c_rom = -16'sd783;
      6'o64: c_rom = -16'sd783;  6'o65: c_rom = 16'sd1892;  6'o66: c_rom = -16'sd1892; 6'o67: c_rom = 16'sd783;
      6'o70: c_rom = 16'sd399;   6'o71: c_rom = -16'sd1137; 6'o72: c_rom = 16'sd1702;  6'o73: c_rom = -16'sd2008;
      6'o74: c_rom = 16'sd2008;  6'o75: c_rom = -16'sd1702; 6'o76: c_rom = 16'sd1137;  6'o77: c_rom = -16'sd399;
      default: c_rom = '0;
    endcase
  end
  assign prod           = rowbuf_q[k_q] * c_rom;
  assign load_idx       = state_q == LOAD1 ? 2'd1 : state_q == LOAD2 ? 2'd2 : state_q == LOAD3 ? 2'd3 : 2'd0;
  assign sp_address_o   = {row_q, load_idx};
  assign t_address_o    = {row_q, col_q};
  assign t_write_data_o = 32'(acc_q >>> SHIFT);
  assign t_we_o         = state_q == WRITE;
  assign done_o         = state_q == DONE;
  assign busy_o         = state_q != IDLE;
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    k_d      = k_q;
    acc_d    = acc_q;
    rowbuf_d = rowbuf_q;
    case (state_q)
      IDLE: if (start_i) begin
        row_d   = '0;
        state_d = LOAD0;
      end
      LOAD0: state_d = LOAD1;
      LOAD1: begin
        rowbuf_d[0] = sp_read_data_i[31:16];
        rowbuf_d[1] = sp_read_data_i[15:0];
        state_d     = LOAD2;
      end
      LOAD2: begin
        rowbuf_d[2] = sp_read_data_i[31:16];
        rowbuf_d[3] = sp_read_data_i[15:0];
        state_d     = LOAD3;
      end
      LOAD3: begin
        rowbuf_d[4] = sp_read_data_i[31:16];
        rowbuf_d[5] = sp_read_data_i[15:0];
        state_d     = LOAD4;
      end
      LOAD4: begin
        rowbuf_d[6] = sp_read_data_i[31:16];
        rowbuf_d[7] = sp_read_data_i[15:0];
        col_d       = '0;
        k_d         = '0;
        acc_d       = '0;
        state_d     = MAC;
      end
      MAC: begin
        acc_d   = acc_q + ACC_W'(prod);
        k_d     = k_q + 3'd1;
        state_d = k_q == 3'd7 ? WRITE : MAC;
      end
      WRITE: begin
        if (col_q != 3'd7) begin
          col_d   = col_q + 3'd1;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end else if (row_q != 3'd7) begin
          row_d   = row_q + 3'd1;
          state_d = LOAD0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rowbuf_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      rowbuf_q <= rowbuf_d;
    end
  end
endmodule

// File: tb/tb_m2_compute_t.sv
// tb_m2_compute_t: directed and random blocks against a floating-point-derived golden IDCT model.
module tb_m2_compute_t;
  logic        clk = 1'b0;
  logic        rst, start, done, t_we, busy;
  logic [4:0]  sp_address;
  logic [5:0]  t_address;
  logic [31:0] sp_read_data, t_write_data;
  logic [31:0] sp_mem [32];
  logic [37:0] sb [$];
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  m2_compute_t dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .done_o(done),
    .sp_address_o(sp_address), .sp_read_data_i(sp_read_data),
    .t_address_o(t_address), .t_write_data_o(t_write_data),
    .t_we_o(t_we), .busy_o(busy)
  );
  always @(posedge clk) sp_read_data <= sp_mem[sp_address];
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (t_we === 1'b1) begin
    logic [37:0] e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL unexpected_write: observed write to %0d expected none", t_address);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("t_address", {26'd0, t_address}, {26'd0, e[37:32]});
      check("t_write_data", t_write_data, e[31:0]);
    end
  end
  function automatic int cval(int k, int j);
    real ck;
    ck = (k == 0) ? $sqrt(0.125) : $sqrt(0.25);
    return $rtoi(ck * 4096.0 * $cos(real'((2 * j + 1) * k) * 3.14159265358979 / 16.0));
  endfunction
  task automatic push_block();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int acc;
        logic signed [15:0] s;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
          s = (k % 2 == 0) ? sp_mem[r * 4 + k / 2][31:16] : sp_mem[r * 4 + k / 2][15:0];
          acc += int'(s) * cval(k, c);
        end
        sb.push_back({6'(r * 8 + c), 32'(acc >>> 8)});
      end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 32; i++) sp_mem[i] = '0;
  endtask
  task automatic rand_mem();
    for (int i = 0; i < 32; i++)
      sp_mem[i] = {16'($urandom_range(4095) - 2048), 16'($urandom_range(4095) - 2048)};
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 2000);
  endtask
  task automatic run_block();
    int cyc;
    push_block();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, 32'd617);
    check("sb_drained", sb.size(), 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask
  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_t_we", {31'd0, t_we}, 32'd0);
    check("rst_sp_address", {27'd0, sp_address}, 32'd0);
    check("rst_t_address", {26'd0, t_address}, 32'd0);
    check("rst_t_write_data", t_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_block();
    sp_mem[0] = {16'd8, 16'd0};
    run_block();
    clear_mem();
    for (int r = 0; r < 8; r++) sp_mem[r * 4] = {16'd256, 16'd0};
    run_block();
    clear_mem();
    sp_mem[0] = {16'd0, 16'hFF00};
    run_block();
    rand_mem();
    push_block();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1;
    repeat (50) @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_t_we", {31'd0, t_we}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    run_block();
    rand_mem();
    push_block();
    start = 1'b1;
    for (int b = 0; b < 20; b++) begin
      wait_done(cyc);
      check("b2b_done_cycle", cyc, b == 0 ? 32'd617 : 32'd618);
      check("b2b_sb_drained", sb.size(), 32'd0);
      if (b < 19) begin
        rand_mem();
        push_block();
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
